// File: rtl/dpram_stream_reader.sv
// Burst read engine for a read-enabled dual-port RAM port, presenting data as a valid/ready stream.
// Define DPRAM_STREAM_READER_ABORT_EN to add the abort input that kills the current burst.
module dpram_stream_reader #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int LEN_W        = 12,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
`ifdef DPRAM_STREAM_READER_ABORT_EN
   ,
   input  logic              abort
`endif
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_S = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [LEN_W-1:0]        remain_q, remain_d;
   logic [CNT_W-1:0]        inflight_q, inflight_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [READ_LATENCY-1:0] tag_last_q, tag_last_d;
   logic                    discard_q, discard_d;
   logic [DATA_W:0]         fifo_mem_q [FIFO_DEPTH];

   logic kill, credit, fifo_empty, capture, push, pop;

`ifdef DPRAM_STREAM_READER_ABORT_EN
   assign kill = abort & (state_q != IDLE);
`else
   assign kill = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      discard_d  = discard_q;
      ram_rden   = 1'b0;
      // Credit counts reads still in the RAM pipe so every capture has a free FIFO slot.
      credit     = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_S;
      fifo_empty = (count_q == '0);
      capture    = tag_vld_q[READ_LATENCY-1];
      push       = capture & ~discard_q & ~kill;
      out_valid  = ~fifo_empty & ~kill;
      pop        = out_valid & out_ready;

      case (state_q)
         IDLE: begin
            if (cmd_valid && (cmd_len != '0)) begin
               addr_d   = cmd_addr;
               remain_d = cmd_len;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (!kill && credit) begin
               ram_rden = 1'b1;
               addr_d   = addr_q + 1'b1;
               remain_d = remain_q - 1'b1;
               if (remain_q == LEN_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((inflight_q == '0) && fifo_empty) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      inflight_d = inflight_q;
      if (ram_rden && !capture)      inflight_d = inflight_q + 1'b1;
      else if (!ram_rden && capture) inflight_d = inflight_q - 1'b1;

      tag_vld_d  = (tag_vld_q << 1) | READ_LATENCY'(ram_rden);
      tag_last_d = (tag_last_q << 1) | READ_LATENCY'(ram_rden && (remain_q == LEN_W'(1)));

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;

      // Abort empties the FIFO now; reads still in the RAM pipe are swallowed until inflight drains.
      if (kill) begin
         discard_d = 1'b1;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         state_d   = (inflight_d == '0) ? IDLE : DRAIN;
      end
      if (state_d == IDLE) discard_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_vld_q  <= '0;
         tag_last_q <= '0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tag_vld_q  <= tag_vld_d;
         tag_last_q <= tag_last_d;
         discard_q  <= discard_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= {tag_last_q[READ_LATENCY-1], ram_q};
   end

   assign cmd_ready   = (state_q == IDLE);
   assign ram_address = addr_q;
   assign out_data    = fifo_mem_q[rd_ptr_q][DATA_W-1:0];
   assign out_last    = fifo_mem_q[rd_ptr_q][DATA_W] & out_valid;
   assign busy        = (state_q != IDLE) | out_valid;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: random-content RAM model plus a queue of expected stream words.
// Build with DPRAM_STREAM_READER_ABORT_EN defined to also exercise the abort path.
module tb_dpram_stream_reader;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 12;
   localparam int RL     = 1;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic [ADDR_W-1:0] ram_address;
   logic              ram_rden;
   logic [DATA_W-1:0] ram_q;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
`ifdef DPRAM_STREAM_READER_ABORT_EN
   logic              abort;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int words_seen = 0;

   logic [DATA_W-1:0] mem [1 << ADDR_W];
   logic [DATA_W-1:0] exp_d [$];
   logic              exp_l [$];
   logic [ADDR_W-1:0] iss_a [$];
   int                iss_c [$];

   dpram_stream_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
      .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .ram_address(ram_address), .ram_rden(ram_rden), .ram_q(ram_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy)
`ifdef DPRAM_STREAM_READER_ABORT_EN
      , .abort(abort)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle read RAM; garbage on q when not enabled so stray captures show up.
   always @(posedge clk) ram_q <= ram_rden ? mem[ram_address] : DATA_W'($urandom);

   // Inputs are driven at negedge, this monitor samples at negedge+2, tasks sample at negedge+3.
   task automatic monitor();
      logic [DATA_W-1:0] ed;
      logic              el;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            if (ram_rden) begin
               iss_a.push_back(ram_address);
               iss_c.push_back(cyc);
               checks++;
               if (cmd_ready) begin
                  failures++;
                  $display("FAIL rden_outside_burst: ram_rden=1 with cmd_ready=%b, required cmd_ready=0 (t=%0t)", cmd_ready, $time);
               end
            end
            if (out_valid && out_ready) begin
               checks++;
               if (exp_d.size() == 0) begin
                  failures++;
                  $display("FAIL stream_extra: got data=%h last=%b, required no word (t=%0t)", out_data, out_last, $time);
               end else begin
                  ed = exp_d.pop_front();
                  el = exp_l.pop_front();
                  words_seen++;
                  if (out_data !== ed || out_last !== el) begin
                     failures++;
                     $display("FAIL stream_word: got data=%h last=%b, required data=%h last=%b (t=%0t)", out_data, out_last, ed, el, $time);
                  end
               end
            end
         end
      end
   endtask

   task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
      int budget;
      int len;
      budget = 0;
      len    = int'(n);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = n;
      #3;
      while (!cmd_ready && budget < 500) begin
         @(negedge clk);
         #3;
         budget++;
      end
      checks++;
      if (!cmd_ready) begin
         failures++;
         $display("FAIL cmd_accept: got cmd_ready=0 after %0d cycles, required 1", budget);
      end
      @(posedge clk);
      if (cmd_ready) begin
         for (int i = 0; i < len; i++) begin
            exp_d.push_back(mem[ADDR_W'(int'(a) + i)]);
            exp_l.push_back(i == len - 1);
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input bit rnd, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < budget) begin
         @(negedge clk);
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #3;
         if (words_seen >= target && exp_d.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      checks++;
      if ({cmd_ready, ram_rden, out_valid, out_last, busy} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_flags: got {cmd_ready,rden,valid,last,busy}=%b, required 10000", {cmd_ready, ram_rden, out_valid, out_last, busy});
      end
      checks++;
      if (ram_address !== '0) begin
         failures++;
         $display("FAIL reset_address: got %h, required 000", ram_address);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int base, first_k;
      bit ok;
      out_ready = 1'b1;
      iss_a.delete();
      iss_c.delete();
      base    = words_seen;
      first_k = -1;
      send_cmd(12'h010, 12'd4);
      for (int k = 1; k <= 12; k++) begin
         #3;
         if (first_k < 0 && out_valid) first_k = k;
         @(negedge clk);
      end
      checks++;
      if (first_k - 1 != RL + 1) begin
         failures++;
         $display("FAIL basic_latency: first word %0d edges after accept, required %0d", first_k - 1, RL + 1);
      end
      wait_done(base + 4, 50, 1'b0, ok);
      checks++;
      if (!ok || words_seen - base != 4) begin
         failures++;
         $display("FAIL basic_count: got %0d words (done=%b), required 4", words_seen - base, ok);
      end
      checks++;
      if (iss_a.size() != 4) begin
         failures++;
         $display("FAIL basic_rden_count: got %0d, required 4", iss_a.size());
      end
      for (int i = 0; i < 4 && i < iss_a.size(); i++) begin
         checks++;
         if (iss_a[i] !== ADDR_W'(12'h010 + i) || iss_c[i] != iss_c[0] + i) begin
            failures++;
            $display("FAIL basic_issue%0d: got addr=%h cycle+%0d, required addr=%h cycle+%0d", i, iss_a[i], iss_c[i] - iss_c[0], ADDR_W'(12'h010 + i), i);
         end
      end
   endtask

   task automatic test_wrap();
      int base;
      bit ok;
      logic [ADDR_W-1:0] start;
      start = 12'hFFE;
      iss_a.delete();
      iss_c.delete();
      base = words_seen;
      send_cmd(start, 12'd4);
      wait_done(base + 4, 100, 1'b1, ok);
      checks++;
      if (!ok || words_seen - base != 4 || iss_a.size() != 4) begin
         failures++;
         $display("FAIL wrap_count: got words=%0d rdens=%0d done=%b, required 4 4 1", words_seen - base, iss_a.size(), ok);
      end
      for (int i = 0; i < 4 && i < iss_a.size(); i++) begin
         checks++;
         if (iss_a[i] !== ADDR_W'(int'(start) + i)) begin
            failures++;
            $display("FAIL wrap_addr%0d: got %h, required %h", i, iss_a[i], ADDR_W'(int'(start) + i));
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      bit ok;
      out_ready = 1'b0;
      iss_a.delete();
      iss_c.delete();
      base = words_seen;
      send_cmd(ADDR_W'($urandom), 12'd16);
      repeat (12) @(negedge clk);
      #3;
      checks++;
      if (iss_a.size() != DEPTH) begin
         failures++;
         $display("FAIL stall_rden_count: got %0d rdens while stalled, required %0d", iss_a.size(), DEPTH);
      end
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL stall_flags: got out_valid=%b busy=%b, required 1 1", out_valid, busy);
      end
      wait_done(base + 16, 400, 1'b1, ok);
      checks++;
      if (!ok || words_seen - base != 16 || iss_a.size() != 16) begin
         failures++;
         $display("FAIL stall_release: got words=%0d rdens=%0d done=%b, required 16 16 1", words_seen - base, iss_a.size(), ok);
      end
   endtask

   task automatic test_zero_len();
      out_ready = 1'b1;
      iss_a.delete();
      iss_c.delete();
      send_cmd(ADDR_W'($urandom), 12'd0);
      for (int k = 0; k < 6; k++) begin
         #3;
         checks++;
         if ({ram_rden, out_valid, busy} !== 3'b000 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_cycle%0d: got rden=%b valid=%b busy=%b ready=%b, required 0 0 0 1", k, ram_rden, out_valid, busy, cmd_ready);
         end
         @(negedge clk);
      end
      checks++;
      if (iss_a.size() != 0) begin
         failures++;
         $display("FAIL zero_len_rden: got %0d rdens, required 0", iss_a.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      int base, n;
      bit ok;
      out_ready = 1'b1;
      base = words_seen;
      n    = 0;
      send_cmd(ADDR_W'($urandom), 12'd8);
      #3;
      while (words_seen - base < 3 && n < 50) begin
         @(negedge clk);
         #3;
         n++;
      end
      checks++;
      if (words_seen - base < 3) begin
         failures++;
         $display("FAIL midreset_reach: got %0d words, required 3", words_seen - base);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({cmd_ready, ram_rden, out_valid, out_last, busy} !== 5'b10000 || ram_address !== '0) begin
         failures++;
         $display("FAIL midreset_outputs: got flags=%b addr=%h, required 10000 000", {cmd_ready, ram_rden, out_valid, out_last, busy}, ram_address);
      end
      exp_d.delete();
      exp_l.delete();
      @(negedge clk);
      reset = 1'b0;
      iss_a.delete();
      iss_c.delete();
      base = words_seen;
      send_cmd(12'h000, 12'd2);
      wait_done(base + 2, 50, 1'b0, ok);
      checks++;
      if (!ok || words_seen - base != 2 || iss_a.size() != 2) begin
         failures++;
         $display("FAIL midreset_next: got words=%0d rdens=%0d done=%b, required 2 2 1", words_seen - base, iss_a.size(), ok);
      end
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] a [6];
      int l [6];
      int total, base, n;
      bit done;
      for (int r = 0; r < 3; r++) begin
         total = 0;
         for (int i = 0; i < 6; i++) begin
            a[i] = ADDR_W'($urandom);
            l[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
            total += l[i];
         end
         base = words_seen;
         done = 1'b0;
         n    = 0;
         fork
            begin
               for (int i = 0; i < 6; i++) send_cmd(a[i], LEN_W'(l[i]));
               done = 1'b1;
            end
            begin
               while (n < 3000 && !(done && exp_d.size() == 0 && !busy)) begin
                  @(negedge clk);
                  out_ready = 1'($urandom_range(0, 1));
                  #3;
                  n++;
               end
            end
         join
         checks++;
         if (n >= 3000 || words_seen - base != total) begin
            failures++;
            $display("FAIL b2b_round%0d: got %0d words in %0d cycles, required %0d words", r, words_seen - base, n, total);
         end
      end
   endtask

`ifdef DPRAM_STREAM_READER_ABORT_EN
   task automatic test_abort();
      int base, n, k;
      bit ok;
      out_ready = 1'b1;
      base = words_seen;
      n    = 0;
      send_cmd(ADDR_W'($urandom), 12'd10);
      #3;
      while (words_seen - base < 2 && n < 50) begin
         @(negedge clk);
         #3;
         n++;
      end
      @(negedge clk);
      abort = 1'b1;
      exp_d.delete();
      exp_l.delete();
      #3;
      checks++;
      if ({out_valid, ram_rden} !== 2'b00) begin
         failures++;
         $display("FAIL abort_cycle: got out_valid=%b rden=%b, required 0 0", out_valid, ram_rden);
      end
      @(negedge clk);
      abort = 1'b0;
      k = 1;
      #3;
      while (!cmd_ready && k < 20) begin
         @(negedge clk);
         #3;
         k++;
      end
      checks++;
      if (!cmd_ready || k > RL + 1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle: got idle after %0d cycles (ready=%b valid=%b), required <= %0d and valid 0", k, cmd_ready, out_valid, RL + 1);
      end
      base = words_seen;
      send_cmd(ADDR_W'($urandom), 12'd5);
      wait_done(base + 5, 100, 1'b1, ok);
      checks++;
      if (!ok || words_seen - base != 5) begin
         failures++;
         $display("FAIL abort_next: got %0d words (done=%b), required 5", words_seen - base, ok);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      out_ready = 1'b0;
`ifdef DPRAM_STREAM_READER_ABORT_EN
      abort     = 1'b0;
`endif
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_reset_mid_burst();
      test_back_to_back();
`ifdef DPRAM_STREAM_READER_ABORT_EN
      test_abort();
`endif
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
